// File: rtl/fdma_wr_arb4.sv
// ---------------------------------------------------------------------------
// fdma_wr_arb4
// Four-channel round-robin write arbiter in front of a single FDMA write
// master. One channel at a time is granted through O_cs; the granted
// channel's request/address/size/data are muxed onto the FDMA, and the FDMA
// busy/valid strobes are routed back to that channel only.
//
// Optional feature macro: FDMA_ARB_STAT_EN
//   defined   : per-channel 32-bit completed-burst counters on O_burst_cnt
//   undefined : counters not built, O_burst_cnt tied to 0
//
// Ports
//   I_ui_clk, I_ui_rstn   clock, synchronous active-low reset
//   I_ch_en[3:0]          channel enable mask (disabled channels never granted)
//   O_cs[3:0]             registered one-hot grant, high only while granting
//   I_ch_wareq/waddr/wsize/wdata   per-channel request bundle (ch k at k*W +: W)
//   O_ch_wbusy/O_ch_wvalid         per-channel return strobes
//   O_fdma_*              muxed request to the FDMA
//   I_fdma_wbusy/wvalid   strobes from the FDMA
//   O_gnt_idx             current or last granted channel
//   O_burst_cnt[127:0]    per-channel completed-burst counters
// ---------------------------------------------------------------------------
module fdma_wr_arb4 #(
    parameter int AXI_DATA_WIDTH = 128,
    parameter int AXI_ADDR_WIDTH = 32
) (
    input  logic                        I_ui_clk,
    input  logic                        I_ui_rstn,
    input  logic [3:0]                  I_ch_en,
    output logic [3:0]                  O_cs,
    input  logic [3:0]                  I_ch_wareq,
    input  logic [4*AXI_ADDR_WIDTH-1:0] I_ch_waddr,
    input  logic [4*16-1:0]             I_ch_wsize,
    input  logic [4*AXI_DATA_WIDTH-1:0] I_ch_wdata,
    output logic [3:0]                  O_ch_wbusy,
    output logic [3:0]                  O_ch_wvalid,
    output logic [AXI_ADDR_WIDTH-1:0]   O_fdma_waddr,
    output logic                        O_fdma_wareq,
    output logic [15:0]                 O_fdma_wsize,
    output logic [AXI_DATA_WIDTH-1:0]   O_fdma_wdata,
    input  logic                        I_fdma_wbusy,
    input  logic                        I_fdma_wvalid,
    output logic [1:0]                  O_gnt_idx,
    output logic [4*32-1:0]             O_burst_cnt
);

    // state   | meaning
    // S_IDLE  | scan enables round-robin from gnt+1, pick the next channel
    // S_GRANT | cs asserted, waiting for the channel's wareq (or enable drop)
    // S_WBUSY | request forwarded, waiting for the FDMA to raise wbusy
    // S_BURST | burst in progress, done when wbusy falls
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WBUSY, S_BURST} state_t;

    state_t     r_state, w_state_nxt;
    logic [1:0] r_gnt, w_gnt_nxt;
    logic [3:0] r_cs;
    logic [1:0] w_cand;

    always_ff @(posedge I_ui_clk) begin
        if (!I_ui_rstn) begin
            r_state <= S_IDLE;
            r_gnt   <= 2'd3;    // channel 0 is scanned first after reset
            r_cs    <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_cs    <= (w_state_nxt == S_GRANT) ? (4'b0001 << w_gnt_nxt) : 4'b0000;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_cand      = r_gnt;
        case (r_state)
            S_IDLE: begin
                // Walk offsets 4..1 so the smallest offset (gnt+1) wins;
                // offset 4 is gnt itself, considered last.
                for (int i = 4; i >= 1; i--) begin
                    w_cand = r_gnt + 2'(i);
                    if (I_ch_en[w_cand]) begin
                        w_gnt_nxt   = w_cand;
                        w_state_nxt = S_GRANT;
                    end
                end
            end
            S_GRANT: begin
                if (I_ch_wareq[r_gnt])
                    w_state_nxt = S_WBUSY;
                else if (!I_ch_en[r_gnt])
                    w_state_nxt = S_IDLE;   // abort; pointer already advanced
            end
            S_WBUSY: begin
                if (I_fdma_wbusy)
                    w_state_nxt = S_BURST;
            end
            S_BURST: begin
                if (!I_fdma_wbusy)
                    w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        O_fdma_waddr = '0;
        O_fdma_wsize = '0;
        O_fdma_wdata = '0;
        for (int k = 0; k < 4; k++) begin
            if (r_gnt == 2'(k)) begin
                O_fdma_waddr = I_ch_waddr[k*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH];
                O_fdma_wsize = I_ch_wsize[k*16 +: 16];
                O_fdma_wdata = I_ch_wdata[k*AXI_DATA_WIDTH +: AXI_DATA_WIDTH];
            end
        end
    end

    // Non-granted channels see busy=1 so their wready stays low.
    always_comb begin
        O_fdma_wareq = 1'b0;
        O_ch_wvalid  = 4'b0000;
        O_ch_wbusy   = 4'b1111;
        if (r_state != S_IDLE) begin
            O_fdma_wareq       = I_ch_wareq[r_gnt];
            O_ch_wvalid[r_gnt] = I_fdma_wvalid;
            O_ch_wbusy[r_gnt]  = I_fdma_wbusy;
        end
    end

    assign O_cs      = r_cs;
    assign O_gnt_idx = r_gnt;

`ifdef FDMA_ARB_STAT_EN
    logic [31:0] r_burst_cnt [4];
    logic        w_burst_done;

    // Only a real burst completion counts; aborted grants never reach S_BURST.
    assign w_burst_done = (r_state == S_BURST) && !I_fdma_wbusy;

    always_ff @(posedge I_ui_clk) begin
        if (!I_ui_rstn) begin
            for (int k = 0; k < 4; k++)
                r_burst_cnt[k] <= 32'd0;
        end else if (w_burst_done) begin
            r_burst_cnt[r_gnt] <= r_burst_cnt[r_gnt] + 32'd1;
        end
    end

    for (genvar g = 0; g < 4; g++) begin : g_cnt_out
        assign O_burst_cnt[g*32 +: 32] = r_burst_cnt[g];
    end
`else
    assign O_burst_cnt = '0;
`endif

endmodule

// File: tb/tb_fdma_wr_arb4.sv
module tb_fdma_wr_arb4;
    localparam int DW = 128;
    localparam int AW = 32;

    logic            I_ui_clk = 1'b0;
    logic            I_ui_rstn;
    logic [3:0]      I_ch_en;
    logic [3:0]      O_cs;
    logic [3:0]      I_ch_wareq;
    logic [4*AW-1:0] I_ch_waddr;
    logic [4*16-1:0] I_ch_wsize;
    logic [4*DW-1:0] I_ch_wdata;
    logic [3:0]      O_ch_wbusy;
    logic [3:0]      O_ch_wvalid;
    logic [AW-1:0]   O_fdma_waddr;
    logic            O_fdma_wareq;
    logic [15:0]     O_fdma_wsize;
    logic [DW-1:0]   O_fdma_wdata;
    logic            I_fdma_wbusy;
    logic            I_fdma_wvalid;
    logic [1:0]      O_gnt_idx;
    logic [127:0]    O_burst_cnt;

    fdma_wr_arb4 #(.AXI_DATA_WIDTH(DW), .AXI_ADDR_WIDTH(AW)) dut (
        .I_ui_clk     (I_ui_clk),
        .I_ui_rstn    (I_ui_rstn),
        .I_ch_en      (I_ch_en),
        .O_cs         (O_cs),
        .I_ch_wareq   (I_ch_wareq),
        .I_ch_waddr   (I_ch_waddr),
        .I_ch_wsize   (I_ch_wsize),
        .I_ch_wdata   (I_ch_wdata),
        .O_ch_wbusy   (O_ch_wbusy),
        .O_ch_wvalid  (O_ch_wvalid),
        .O_fdma_waddr (O_fdma_waddr),
        .O_fdma_wareq (O_fdma_wareq),
        .O_fdma_wsize (O_fdma_wsize),
        .O_fdma_wdata (O_fdma_wdata),
        .I_fdma_wbusy (I_fdma_wbusy),
        .I_fdma_wvalid(I_fdma_wvalid),
        .O_gnt_idx    (O_gnt_idx),
        .O_burst_cnt  (O_burst_cnt)
    );

    always #5 I_ui_clk = ~I_ui_clk;

    int           n_chk = 0;
    int           n_err = 0;
    logic [127:0] exp_cnt = '0;

    task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge I_ui_clk);
        #1;
    endtask

    function automatic logic [AW-1:0] ch_addr(input int k);
        return 32'h1000_0000 + 32'(k) * 32'h100;
    endfunction

    function automatic logic [DW-1:0] ch_data(input int k);
        return {4{32'hA5A5_0000 + 32'(k)}};
    endfunction

    function automatic logic [15:0] ch_size(input int k);
        return (k == 2) ? 16'd240 : 16'(16 * (k + 1));
    endfunction

    function automatic logic [127:0] cnt_exp();
`ifdef FDMA_ARB_STAT_EN
        return exp_cnt;
`else
        return '0;
`endif
    endfunction

    // Ticks until O_cs goes non-zero (bounded); returns ticks consumed.
    task automatic wait_cs(output int waited);
        waited = 0;
        do begin
            tick();
            waited++;
        end while (O_cs == 4'b0000 && waited < 20);
    endtask

    // Full grant/burst cycle on channel g, entered from S_IDLE.
    task automatic burst(input int g, input int busy_n, input int v_n);
        int w;
        int vcnt;
        int bad;
        wait_cs(w);
        chk("grant_latency", w, 1);
        chk("cs_onehot", O_cs, 4'b0001 << g);
        chk("gnt_idx", O_gnt_idx, g);
        chk("fdma_wareq", O_fdma_wareq, 1);
        chk("fdma_waddr", O_fdma_waddr, ch_addr(g));
        chk("fdma_wsize", O_fdma_wsize, ch_size(g));
        chk("fdma_wdata", O_fdma_wdata, ch_data(g));
        tick();
        chk("cs_drop", O_cs, 0);
        chk("wareq_wbusy_state", O_fdma_wareq, 1);
        I_fdma_wbusy = 1'b1;
        tick();
        vcnt = 0;
        bad  = 0;
        for (int i = 0; i < busy_n; i++) begin
            I_fdma_wvalid = (i < v_n);
            #1;
            if (O_ch_wvalid == (4'b0001 << g)) vcnt++;
            else if (O_ch_wvalid != 4'b0000) bad++;
            if (O_ch_wbusy != 4'hF) bad++;
            if (O_cs != 4'b0000) bad++;
            tick();
        end
        chk("wvalid_cycles", vcnt, v_n);
        chk("burst_side_bad", bad, 0);
        I_fdma_wvalid = 1'b0;
        I_fdma_wbusy  = 1'b0;
        #1;
        chk("ch_wbusy_route", O_ch_wbusy, 4'hF & ~(4'b0001 << g));
        tick();
        exp_cnt[g*32 +: 32] = exp_cnt[g*32 +: 32] + 32'd1;
        chk("idle_cs", O_cs, 0);
        chk("idle_wbusy", O_ch_wbusy, 4'hF);
        chk("burst_cnt", O_burst_cnt, cnt_exp());
    endtask

    initial begin
        int w;
        int bad;
        I_ui_rstn     = 1'b0;
        I_ch_en       = 4'hF;
        I_ch_wareq    = 4'hF;
        I_fdma_wbusy  = 1'b0;
        I_fdma_wvalid = 1'b0;
        for (int k = 0; k < 4; k++) begin
            I_ch_waddr[k*AW +: AW] = ch_addr(k);
            I_ch_wsize[k*16 +: 16] = ch_size(k);
            I_ch_wdata[k*DW +: DW] = ch_data(k);
        end
        tick();
        tick();
        chk("rst_cs", O_cs, 0);
        chk("rst_gnt", O_gnt_idx, 3);
        chk("rst_wareq", O_fdma_wareq, 0);
        chk("rst_wvalid", O_ch_wvalid, 0);
        chk("rst_wbusy", O_ch_wbusy, 4'hF);
        chk("rst_cnt", O_burst_cnt, 0);

        // All enabled and requesting: 0,1,2,3,0
        I_ui_rstn = 1'b1;
        burst(0, 4, 2);
        burst(1, 3, 0);
        burst(2, 5, 5);
        burst(3, 2, 1);
        burst(0, 3, 0);

        // Only ch2: three long bursts, each re-granted 2 cycles after wbusy falls
        I_ch_en = 4'b0100;
        burst(2, 250, 0);
        burst(2, 250, 0);
        burst(2, 250, 0);

        // Ch1 granted without wareq, then disabled: abort, ch3 next
        I_ch_en    = 4'b0010;
        I_ch_wareq = 4'b1000;
        wait_cs(w);
        chk("abort_grant_lat", w, 1);
        chk("abort_cs", O_cs, 4'b0010);
        chk("abort_gnt", O_gnt_idx, 1);
        chk("abort_no_wareq", O_fdma_wareq, 0);
        I_ch_en = 4'b1010;
        bad = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (O_cs != 4'b0010) bad++;
        end
        chk("abort_hold", bad, 0);
        I_ch_en = 4'b1000;
        tick();
        chk("abort_cs_drop", O_cs, 0);
        chk("abort_idle_wbusy", O_ch_wbusy, 4'hF);
        burst(3, 5, 0);
        I_ch_wareq = 4'hF;

        // Ch0 burst with 240 cycles of wvalid
        I_ch_en = 4'b0001;
        burst(0, 250, 240);

        // Reset in the middle of a ch2 burst
        I_ch_en = 4'b0100;
        wait_cs(w);
        chk("rb_gnt", O_gnt_idx, 2);
        tick();
        I_fdma_wbusy = 1'b1;
        tick();
        tick();
        tick();
        I_ui_rstn = 1'b0;
        tick();
        exp_cnt = '0;
        chk("rb_cs", O_cs, 0);
        chk("rb_wareq", O_fdma_wareq, 0);
        chk("rb_gnt_rst", O_gnt_idx, 3);
        chk("rb_cnt", O_burst_cnt, 0);
        chk("rb_wbusy", O_ch_wbusy, 4'hF);
        I_ui_rstn    = 1'b1;
        I_fdma_wbusy = 1'b0;
        I_ch_en      = 4'hF;
        burst(0, 3, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
